// File: rtl/interrupt_source_controller_pkg.sv
// Shared constants for the interrupt source controller: register offsets,
// default window base, reset values and the CLAIM priority helper.
package interrupt_source_controller_pkg;

  localparam int          INTC_MAX_SRC      = 8;
  localparam logic [31:0] INTC_BASE_ADDR    = 32'hFF20_0300;

  localparam logic [4:0]  INTC_OFF_PENDING  = 5'h00;
  localparam logic [4:0]  INTC_OFF_ENABLE   = 5'h04;
  localparam logic [4:0]  INTC_OFF_MODE     = 5'h08;
  localparam logic [4:0]  INTC_OFF_POLARITY = 5'h0C;
  localparam logic [4:0]  INTC_OFF_CLAIM    = 5'h10;
  localparam logic [4:0]  INTC_OFF_SOFT     = 5'h14;

  localparam logic [7:0]  INTC_MODE_RST     = 8'hFF;
  localparam logic [7:0]  INTC_POL_RST      = 8'hFF;

  // Returns {valid, id[4:0]} for the lowest-numbered set bit of v.
  function automatic logic [5:0] intc_lowest_set(input logic [INTC_MAX_SRC-1:0] v);
    logic [4:0] id;
    logic       valid;
    id    = 5'd0;
    valid = 1'b0;
    for (int i = INTC_MAX_SRC - 1; i >= 0; i--) begin
      id    = v[i] ? 5'(i) : id;
      valid = valid | v[i];
    end
    return {valid, id};
  endfunction

endpackage

// File: rtl/interrupt_source_controller_sync_edge.sv
// Per-source synchroniser chain, polarity qualification and rising-edge
// detection of the qualified (asserted-high) line.
module intc_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic iCLK,
  input  logic iRST_n,
  input  logic iIrq,
  input  logic iPolarity,
  output logic oQ,
  output logic oRise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_q_prev;
  logic                   w_q;

  assign w_q   = ~(r_sync[SYNC_STAGES-1] ^ iPolarity);
  assign oQ    = w_q;
  assign oRise = w_q & ~r_q_prev;

  // Synchroniser shift chain and previous qualified value for edge detect.
  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      r_sync   <= '0;
      r_q_prev <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], iIrq};
      r_q_prev <= w_q;
    end
  end

endmodule

// File: rtl/interrupt_source_controller.sv
// Memory-mapped interrupt source controller feeding iPendingInterrupt.
// Optional CLAIM priority encoder enabled by macro INTC_PRIORITY_CLAIM_EN.
module interrupt_source_controller
  import interrupt_source_controller_pkg::*;
#(
  parameter int          NUM_SRC     = 8,
  parameter logic [31:0] BASE_ADDR   = INTC_BASE_ADDR,
  parameter int          SYNC_STAGES = 2
) (
  input  logic               iCLK,
  input  logic               iRST_n,
  input  logic [NUM_SRC-1:0] iIrqSrc,
  input  logic [31:0]        iAddress,
  input  logic               iReadEnable,
  input  logic               iWriteEnable,
  input  logic [3:0]         iByteEnable,
  input  logic [31:0]        iWriteData,
  output logic [31:0]        oReadData,
  output logic               oSelected,
  output logic [NUM_SRC-1:0] oPendingInterrupt
);

  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] r_enable;
  logic [NUM_SRC-1:0] r_mode;
  logic [NUM_SRC-1:0] r_polarity;

  logic [NUM_SRC-1:0] w_q;
  logic [NUM_SRC-1:0] w_rise;
  logic [NUM_SRC-1:0] w_w1c;
  logic [NUM_SRC-1:0] w_soft;
  logic [NUM_SRC-1:0] w_wdata;
  logic [NUM_SRC-1:0] w_pend_next;
  logic               w_wr_en;
  logic               w_wr_enable;
  logic               w_wr_mode;
  logic               w_wr_pol;
  logic [31:0]        w_rel;
  logic [4:0]         w_off;
  logic               w_selected;
  logic [31:0]        w_pend32;
  logic [31:0]        w_en32;
  logic [31:0]        w_mode32;
  logic [31:0]        w_pol32;
  logic [31:0]        w_claim_word;
  logic [31:0]        w_read_data;
  logic               w_unused;

  // Unsigned distance from the base also rejects addresses below it.
  assign w_rel      = iAddress - BASE_ADDR;
  assign w_selected = (w_rel < 32'd32);
  assign w_off      = {w_rel[4:2], 2'b00};
  assign w_wr_en    = w_selected & iWriteEnable & iByteEnable[0];
  assign w_wdata    = iWriteData[NUM_SRC-1:0];
  assign w_unused   = ^{iReadEnable, iWriteData[31:NUM_SRC], iByteEnable[3:1], w_rel[1:0]};

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    intc_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
      .iCLK      (iCLK),
      .iRST_n    (iRST_n),
      .iIrq      (iIrqSrc[g]),
      .iPolarity (r_polarity[g]),
      .oQ        (w_q[g]),
      .oRise     (w_rise[g])
    );
  end

  // Decode register write strobes and the W1C/SOFT masks.
  always_comb begin
    w_w1c       = '0;
    w_soft      = '0;
    w_wr_enable = 1'b0;
    w_wr_mode   = 1'b0;
    w_wr_pol    = 1'b0;
    if (w_wr_en) begin
      case (w_off)
        INTC_OFF_PENDING:  w_w1c       = w_wdata;
        INTC_OFF_ENABLE:   w_wr_enable = 1'b1;
        INTC_OFF_MODE:     w_wr_mode   = 1'b1;
        INTC_OFF_POLARITY: w_wr_pol    = 1'b1;
        INTC_OFF_SOFT:     w_soft      = w_wdata;
        default:           w_w1c       = '0;
      endcase
    end else begin
      w_w1c = '0;
    end
  end

  // Edge sources latch with set-over-clear; level sources follow q each cycle.
  assign w_pend_next = (r_mode & ((r_pending & ~w_w1c) | w_rise | w_soft)) |
                       (~r_mode & (w_q | w_soft));

  // Control and pending registers.
  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      r_pending  <= '0;
      r_enable   <= '0;
      r_mode     <= INTC_MODE_RST[NUM_SRC-1:0];
      r_polarity <= INTC_POL_RST[NUM_SRC-1:0];
    end else begin
      r_pending  <= w_pend_next;
      r_enable   <= w_wr_enable ? w_wdata : r_enable;
      r_mode     <= w_wr_mode   ? w_wdata : r_mode;
      r_polarity <= w_wr_pol    ? w_wdata : r_polarity;
    end
  end

  // Zero-extend the implemented register bits to the bus width.
  always_comb begin
    w_pend32                 = 32'h0;
    w_en32                   = 32'h0;
    w_mode32                 = 32'h0;
    w_pol32                  = 32'h0;
    w_pend32[NUM_SRC-1:0]    = r_pending;
    w_en32[NUM_SRC-1:0]      = r_enable;
    w_mode32[NUM_SRC-1:0]    = r_mode;
    w_pol32[NUM_SRC-1:0]     = r_polarity;
  end

`ifdef INTC_PRIORITY_CLAIM_EN
  logic [INTC_MAX_SRC-1:0] w_pe8;
  logic [5:0]              w_claim;

  // Widen PENDING & ENABLE to the encoder width.
  always_comb begin
    w_pe8              = '0;
    w_pe8[NUM_SRC-1:0] = r_pending & r_enable;
  end

  assign w_claim      = intc_lowest_set(w_pe8);
  assign w_claim_word = {w_claim[5], 26'h0, w_claim[4:0]};
`else
  assign w_claim_word = 32'h0;
`endif

  // Combinational read mux, valid in the same cycle as the address.
  always_comb begin
    w_read_data = 32'h0;
    if (w_selected) begin
      case (w_off)
        INTC_OFF_PENDING:  w_read_data = w_pend32;
        INTC_OFF_ENABLE:   w_read_data = w_en32;
        INTC_OFF_MODE:     w_read_data = w_mode32;
        INTC_OFF_POLARITY: w_read_data = w_pol32;
        INTC_OFF_CLAIM:    w_read_data = w_claim_word;
        default:           w_read_data = 32'h0;
      endcase
    end else begin
      w_read_data = 32'h0;
    end
  end

  assign oReadData         = w_read_data;
  assign oSelected         = w_selected;
  assign oPendingInterrupt = r_pending & r_enable;

endmodule

// File: tb/tb_interrupt_source_controller.sv
// Directed, table-driven bench for interrupt_source_controller.
// Honours INTC_PRIORITY_CLAIM_EN for the expected CLAIM value.
module tb_interrupt_source_controller;

  localparam logic [31:0] BASE = 32'hFF20_0300;

  logic        clk;
  logic        rst_n;
  logic [7:0]  irq;
  logic [31:0] addr;
  logic        re;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        sel;
  logic [7:0]  pend;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        wr;
    logic [7:0]  off;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[13];

  interrupt_source_controller dut (
    .iCLK              (clk),
    .iRST_n            (rst_n),
    .iIrqSrc           (irq),
    .iAddress          (addr),
    .iReadEnable       (re),
    .iWriteEnable      (we),
    .iByteEnable       (be),
    .iWriteData        (wdata),
    .oReadData         (rdata),
    .oSelected         (sel),
    .oPendingInterrupt (pend)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // All bus tasks start and end at a negedge.
  task automatic bus_write(input logic [7:0] off, input logic [31:0] d, input logic [3:0] b);
    addr  = BASE + {24'h0, off};
    wdata = d;
    be    = b;
    we    = 1'b1;
    @(negedge clk);
    we    = 1'b0;
    be    = 4'h0;
    wdata = 32'h0;
  endtask

  task automatic check_rd(input string name, input logic [7:0] off, input logic [31:0] exp);
    addr = BASE + {24'h0, off};
    re   = 1'b1;
    #1;
    check(name, rdata, exp);
    re   = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] exp_claim;
`ifdef INTC_PRIORITY_CLAIM_EN
    exp_claim = 32'h8000_0003;
`else
    exp_claim = 32'h0000_0000;
`endif
    vecs[0]  = '{1'b0, 8'h04, 4'h0, 32'h0000_0000, 32'h0000_0000};
    vecs[1]  = '{1'b0, 8'h08, 4'h0, 32'h0000_0000, 32'h0000_00FF};
    vecs[2]  = '{1'b0, 8'h0C, 4'h0, 32'h0000_0000, 32'h0000_00FF};
    vecs[3]  = '{1'b0, 8'h00, 4'h0, 32'h0000_0000, 32'h0000_0000};
    vecs[4]  = '{1'b1, 8'h04, 4'h1, 32'h0000_00A5, 32'h0000_00A5};
    vecs[5]  = '{1'b1, 8'h04, 4'hE, 32'hFFFF_FF3C, 32'h0000_00A5};
    vecs[6]  = '{1'b1, 8'h06, 4'h1, 32'h0000_0011, 32'h0000_0011};
    vecs[7]  = '{1'b1, 8'h08, 4'hF, 32'hFFFF_FF0F, 32'h0000_000F};
    vecs[8]  = '{1'b1, 8'h0C, 4'h1, 32'h0000_0033, 32'h0000_0033};
    vecs[9]  = '{1'b1, 8'h18, 4'h1, 32'h0000_00FF, 32'h0000_0000};
    vecs[10] = '{1'b1, 8'h1C, 4'h1, 32'h0000_00FF, 32'h0000_0000};
    vecs[11] = '{1'b0, 8'h14, 4'h0, 32'h0000_0000, 32'h0000_0000};
    vecs[12] = '{1'b1, 8'h14, 4'h1, 32'h0000_0000, 32'h0000_0000};

    rst_n = 1'b0; irq = 8'h00; addr = 32'h0; re = 1'b0; we = 1'b0;
    be = 4'h0; wdata = 32'h0;
    @(negedge clk);
    do_reset();

    check("reset_pend_out", {24'h0, pend}, 32'h0);
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].off, vecs[i].wdata, vecs[i].be);
      check_rd($sformatf("vec%0d", i), vecs[i].off, vecs[i].exp);
    end

    // Edge latency and W1C on source 0.
    do_reset();
    bus_write(8'h04, 32'h01, 4'h1);
    irq[0] = 1'b1;
    @(negedge clk);
    irq[0] = 1'b0;
    check("edge_lat1", {24'h0, pend}, 32'h00);
    @(negedge clk);
    check("edge_lat2", {24'h0, pend}, 32'h00);
    @(negedge clk);
    check("edge_lat3", {24'h0, pend}, 32'h01);
    repeat (3) @(negedge clk);
    check("edge_hold", {24'h0, pend}, 32'h01);
    bus_write(8'h00, 32'h01, 4'h1);
    check("edge_w1c_out", {24'h0, pend}, 32'h00);
    check_rd("edge_w1c_rd", 8'h00, 32'h00);

    // Level mode, active-low source 2.
    do_reset();
    bus_write(8'h08, 32'h00, 4'h1);
    bus_write(8'h0C, 32'hFB, 4'h1);
    bus_write(8'h04, 32'h04, 4'h1);
    check("lvl_idle_out", {24'h0, pend}, 32'h04);
    check_rd("lvl_idle_rd", 8'h00, 32'h04);
    irq[2] = 1'b1;
    repeat (2) @(negedge clk);
    check("lvl_clr_lat2", {24'h0, pend}, 32'h04);
    @(negedge clk);
    check("lvl_clr_lat3", {24'h0, pend}, 32'h00);
    irq[2] = 1'b0;
    repeat (3) @(negedge clk);
    check("lvl_reassert", {24'h0, pend}, 32'h04);
    bus_write(8'h00, 32'h04, 4'h1);
    check_rd("lvl_w1c_rd", 8'h00, 32'h04);

    // Disabled source still latches; enabling exposes it.
    do_reset();
    irq[5] = 1'b1;
    repeat (4) @(negedge clk);
    irq[5] = 1'b0;
    check("dis_out", {24'h0, pend}, 32'h00);
    check_rd("dis_rd", 8'h00, 32'h20);
    bus_write(8'h04, 32'h20, 4'h1);
    check("en_out", {24'h0, pend}, 32'h20);

    // Set wins over a same-cycle W1C; SOFT sets pending.
    do_reset();
    bus_write(8'h04, 32'hFF, 4'h1);
    irq[3] = 1'b1;
    repeat (2) @(negedge clk);
    bus_write(8'h00, 32'h08, 4'h1);
    check_rd("setwins_rd", 8'h00, 32'h08);
    bus_write(8'h00, 32'h08, 4'h1);
    check_rd("w1c_after_rd", 8'h00, 32'h00);
    irq[3] = 1'b0;
    bus_write(8'h14, 32'h80, 4'h1);
    check_rd("soft_rd", 8'h00, 32'h80);
    check("soft_out", {24'h0, pend}, 32'h80);
    check_rd("soft_reads0", 8'h14, 32'h00);

    // SOFT on a level source lasts one cycle.
    do_reset();
    bus_write(8'h08, 32'h00, 4'h1);
    bus_write(8'h04, 32'hFF, 4'h1);
    bus_write(8'h14, 32'h02, 4'h1);
    check("lvl_soft_on", {24'h0, pend}, 32'h02);
    @(negedge clk);
    check("lvl_soft_off", {24'h0, pend}, 32'h00);

    // CLAIM and address window.
    do_reset();
    bus_write(8'h14, 32'h28, 4'h1);
    bus_write(8'h04, 32'hFF, 4'h1);
    check_rd("claim_set", 8'h10, exp_claim);
    bus_write(8'h00, 32'h28, 4'h1);
    check_rd("claim_none", 8'h10, 32'h0);
    bus_write(8'h14, 32'h01, 4'h1);
    addr = BASE + 32'h20;
    #1;
    check("oob_sel", {31'h0, sel}, 32'h0);
    check("oob_rdata", rdata, 32'h0);
    addr = BASE - 32'h4;
    #1;
    check("below_sel", {31'h0, sel}, 32'h0);
    addr = BASE + 32'h1C;
    #1;
    check("top_sel", {31'h0, sel}, 32'h1);
    check_rd("pend_rd_base", 8'h00, 32'h01);

    // Reset mid-operation discards pending state.
    bus_write(8'h14, 32'h0F, 4'h1);
    check("pre_rst_out", {24'h0, pend}, 32'h0F);
    do_reset();
    check("post_rst_out", {24'h0, pend}, 32'h00);
    check_rd("post_rst_pend", 8'h00, 32'h00);
    check_rd("post_rst_en", 8'h04, 32'h00);
    check_rd("post_rst_mode", 8'h08, 32'hFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
